// File: rtl/uart_bus_master.sv
// UART debug initiator: 'W' ADDR DATA and 'R' ADDR commands drive single cycles on the 8-bit peripheral bus.
// Build with UART_BUS_MASTER_WRITE_ACK_EN defined to have writes answered with a 'K' byte.
module uart_bus_master #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       i_uart_rx,
    output logic       o_uart_tx,
    input  logic [7:0] i_peripDataToCPU,
    output logic [7:0] o_peripAddr,
    output logic [7:0] o_peripDataFromCPU,
    output logic       o_peripWrSig,
    output logic       o_peripRdSig,
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [3:0] {
        S_IDLE, S_GET_WADDR, S_GET_WDATA, S_BUS_WR, S_ACK, S_GET_RADDR,
        S_BUS_RD, S_RD_WAIT, S_RD_CAP, S_SEND, S_SEND_WAIT
    } state_t;

    rx_state_t       rx_state;
    logic            rx_s1, rx_s2, rx_s3;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_byte;
    logic            rx_valid;

    tx_state_t       tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shreg;
    logic [7:0]      tx_byte;
    logic            tx_load;
    logic            tx_done;

    state_t          state, state_nxt;

    // RX: rx_s3 is only used to see the falling edge that opens a frame
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= i_uart_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt  <= '0;
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                        rx_bit  <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == LAST) begin
                        rx_state <= RX_IDLE;
                        rx_valid <= rx_s2;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shreg  <= '0;
            o_uart_tx <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_load) begin
                        tx_shreg  <= tx_byte;
                        o_uart_tx <= 1'b0;
                        tx_cnt    <= '0;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt    <= '0;
                        tx_bit    <= '0;
                        o_uart_tx <= tx_shreg[0];
                        tx_state  <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            o_uart_tx <= 1'b1;
                            tx_state  <= TX_STOP;
                        end else begin
                            o_uart_tx <= tx_shreg[1];
                            tx_shreg  <= {1'b0, tx_shreg[7:1]};
                            tx_bit    <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == LAST) begin
                        tx_state <= TX_IDLE;
                        tx_done  <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Bytes arriving outside IDLE/GET_* fall through the default hold and are lost
    always_comb begin
        state_nxt    = state;
        o_peripWrSig = 1'b0;
        o_peripRdSig = 1'b0;
        tx_load      = 1'b0;
        o_busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (rx_valid && rx_byte == 8'h57)
                    state_nxt = S_GET_WADDR;
                else if (rx_valid && rx_byte == 8'h52)
                    state_nxt = S_GET_RADDR;
            end
            S_GET_WADDR: if (rx_valid) state_nxt = S_GET_WDATA;
            S_GET_WDATA: if (rx_valid) state_nxt = S_BUS_WR;
            S_BUS_WR: begin
                o_peripWrSig = 1'b1;
`ifdef UART_BUS_MASTER_WRITE_ACK_EN
                state_nxt    = S_ACK;
`else
                state_nxt    = S_IDLE;
`endif
            end
            S_ACK:       state_nxt = S_SEND;
            S_GET_RADDR: if (rx_valid) state_nxt = S_BUS_RD;
            S_BUS_RD: begin
                o_peripRdSig = 1'b1;
                state_nxt    = S_RD_WAIT;
            end
            S_RD_WAIT:   state_nxt = S_RD_CAP;
            S_RD_CAP:    state_nxt = S_SEND;
            S_SEND: begin
                tx_load   = 1'b1;
                state_nxt = S_SEND_WAIT;
            end
            S_SEND_WAIT: if (tx_done) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            o_peripAddr        <= '0;
            o_peripDataFromCPU <= '0;
            tx_byte            <= '0;
        end else begin
            if (rx_valid && (state == S_GET_WADDR || state == S_GET_RADDR))
                o_peripAddr <= rx_byte;
            if (rx_valid && state == S_GET_WDATA)
                o_peripDataFromCPU <= rx_byte;
            if (state == S_RD_CAP)
                tx_byte <= i_peripDataToCPU;
            if (state == S_ACK)
                tx_byte <= 8'h4B;
        end
    end
endmodule
